syncore_ram_arb: RTL
====================

# syncore_ram_arb

Two-requester arbiter and sequencer for the single-port synchronous FPGA RAM (`syncore_fpgaram`) used in the CPU subsystem. It grants the RAM's single port to one of two requesters per cycle and drives the RAM address, data and write-enable. It tracks outstanding reads through the RAM's fixed read latency and returns each read datum to the requester that issued it. An optional bounded burst lock lets one requester hold the port for back-to-back beats.

## Interface
- DATAWIDTH, 32, RAM word width.
- ADDRWIDTH, 10, RAM address width.
- RD_LATENCY, 1, cycles from the accepted read beat to valid `RamDataOut`; legal values are 1 and 2.
- MAX_BURST, 8, maximum beats per lock tenure; legal range 2..255.

Ports:
- PortClk  in  1  clock.
- PortResetN  in  1  reset. One clock; reset is asynchronous and active-low.
- Req0Valid, Req1Valid  in  1  request valid.
- Req0Addr, Req1Addr  in  ADDRWIDTH  beat address.
- Req0Wen, Req1Wen  in  1  1 = write, 0 = read.
- Req0WData, Req1WData  in  DATAWIDTH  write data.
- Req0Lock, Req1Lock  in  1  request or hold the burst lock.
- Req0Ready, Req1Ready  out  1  grant. A beat is accepted in any cycle where Valid && Ready.
- Rsp0Valid, Rsp1Valid  out  1  read data valid. Single-cycle pulse with no backpressure.
- Rsp0Data, Rsp1Data  out  DATAWIDTH  read data.
- RamAddr  out  ADDRWIDTH  to the RAM's `PortAAddr`.
- RamDataIn  out  DATAWIDTH  to the RAM's `PortADataIn`.
- RamWriteEnable  out  1  to the RAM's `PortAWriteEnable`.
- RamDataOut  in  DATAWIDTH  from the RAM's `PortADataOut`.

## Operation
- **Grant is combinational.** At most one Ready is high per cycle. Ready is only asserted to a requester whose Valid is high.
- **Arbitration order:**
  1. Lock owner valid: grant the owner.
  2. Single valid: grant it.
  3. Both valid: apply the tie policy (see Configuration).
- **RAM drive:** RamAddr, RamDataIn and RamWriteEnable mux from the granted requester. With no grant, all are 0.
- **Writes:** complete on acceptance and produce no response.
- **Reads:** an accepted read pushes {valid, id} into a RD_LATENCY-deep pipeline. At the pipeline output, RspNValid pulses for the matching id and RspNData = RamDataOut. Both RspNData outputs carry RamDataOut every cycle; only RspNValid qualifies them.
- **Lock states:** UNLOCKED, LOCKED0, LOCKED1, with an 8-bit beat counter.
  - UNLOCKED -> LOCKEDn when port n has a beat accepted with Lock=1. The counter is set to 1.
  - While LOCKEDn, each accepted owner beat increments the counter.
  - LOCKEDn -> UNLOCKED when any of these occurs:
    - an owner beat is accepted with Lock=0;
    - the owner's Valid is low in a cycle;
    - an accepted owner beat brings the counter to MAX_BURST.
  - On a forced MAX_BURST release, the other port is forced to win the next tie, regardless of configuration.
- **Last-grant pointer** updates on every accepted beat.

## Timing
- Request to Ready: 0 cycles (same cycle).
- Accepted read in cycle T -> RspNValid in cycle T+RD_LATENCY.
- Reads and writes may be issued every cycle. Throughput is one beat per cycle total.
- A write at T followed by a read of the same address at T+1 returns the new data; the RAM provides write-first behaviour.
- Reset values:
  - all Ready, RspValid, RamWriteEnable, RamAddr and RamDataIn: 0;
  - lock state: UNLOCKED; counter: 0;
  - last-grant pointer: port 1, so port 0 wins the first tie.
- Reset mid-operation: in-flight reads are discarded and no response is issued after reset deasserts.

## Configuration
- Macro: SYNCORE_RAM_ARB_RR_EN.
  - Defined: ties go round-robin; the requester not granted last wins.
  - Undefined: fixed priority; port 0 wins every tie. A MAX_BURST forced release still hands the next tie to the other port.
- The macro does not affect lock or latency behaviour.

## Structure
- Package `syncore_ram_arb_pkg`:
  - requester-id constants REQ0 and REQ1;
  - lock-state encoding;
  - a response-tag struct {valid, id}.
- Sub-module `syncore_ram_arb_rsp_pipe`: parameterised RD_LATENCY shift register of response tags, with async active-low clear.
- Arbitration, lock FSM and RAM muxing live in the top module.

## Test plan
- **Single read:** port 0 writes 0xA5A5_0001 to address 0x010, then reads 0x010 -> Rsp0Valid at T+RD_LATENCY with Rsp0Data = 0xA5A5_0001; Rsp1Valid stays 0.
- **Tie policy:** both ports read every cycle for 6 cycles.
  - With RR_EN: grants alternate 0,1,0,1,0,1.
  - Without RR_EN: port 0 wins all 6.
  - In both cases, the responses carry the correct ids.
- **Burst lock:** port 1 holds Lock=1 with Valid continuously while port 0 is valid, MAX_BURST=4 -> port 1 is granted 4 consecutive beats, then port 0 is granted next (also without RR_EN).
- **Lock release:** port 0 locks, then drops Valid for one cycle -> state returns to UNLOCKED and the pending port 1 is granted that cycle.
- **Write-then-read same address:** port 0 writes 0x1234 to 0x3FF and port 1 reads 0x3FF in the next cycle -> Rsp1Data = 0x1234.
- **Reset with reads in flight:** assert PortResetN low with 2 reads in flight at RD_LATENCY=2 -> no RspValid after release; all outputs are 0 during reset.

Source files
------------

// File: rtl/syncore_ram_arb_pkg.sv
// ============================================================================
// syncore_ram_arb_pkg : shared ids, lock-state encoding and response tag type
// Rev 1.0
// ============================================================================
`default_nettype none

package syncore_ram_arb_pkg;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED0  = 2'd1,
    LOCKED1  = 2'd2
  } lock_state_e;

  typedef struct packed {
    logic valid;
    logic id;
  } rsp_tag_t;

  function automatic logic other_id(input logic id);
    return ~id;
  endfunction

endpackage

`default_nettype wire

// File: rtl/syncore_ram_arb_rsp_pipe.sv
// ============================================================================
// syncore_ram_arb_rsp_pipe : RD_LATENCY-deep shift register of read tags
// Rev 1.0
// ============================================================================
`default_nettype none

module syncore_ram_arb_rsp_pipe
  import syncore_ram_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  rsp_tag_t tag_in,
  output rsp_tag_t tag_out
);

  rsp_tag_t [RD_LATENCY-1:0] stage_q;
  rsp_tag_t [RD_LATENCY-1:0] stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = tag_in;
    for (int i = 1; i < RD_LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Clearing on reset drops in-flight reads so no stale response escapes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_out = stage_q[RD_LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/syncore_ram_arb.sv
// ============================================================================
// syncore_ram_arb : two-requester arbiter/sequencer for a single-port RAM.
// Optional macro SYNCORE_RAM_ARB_RR_EN: round-robin ties (else port 0 wins).
// Rev 1.0
// ============================================================================
`default_nettype none

module syncore_ram_arb
  import syncore_ram_arb_pkg::*;
#(
  parameter int DATAWIDTH  = 32,
  parameter int ADDRWIDTH  = 10,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 8
) (
  input  logic                 PortClk,
  input  logic                 PortResetN,
  input  logic                 Req0Valid,
  input  logic [ADDRWIDTH-1:0] Req0Addr,
  input  logic                 Req0Wen,
  input  logic [DATAWIDTH-1:0] Req0WData,
  input  logic                 Req0Lock,
  input  logic                 Req1Valid,
  input  logic [ADDRWIDTH-1:0] Req1Addr,
  input  logic                 Req1Wen,
  input  logic [DATAWIDTH-1:0] Req1WData,
  input  logic                 Req1Lock,
  output logic                 Req0Ready,
  output logic                 Req1Ready,
  output logic                 Rsp0Valid,
  output logic [DATAWIDTH-1:0] Rsp0Data,
  output logic                 Rsp1Valid,
  output logic [DATAWIDTH-1:0] Rsp1Data,
  output logic [ADDRWIDTH-1:0] RamAddr,
  output logic [DATAWIDTH-1:0] RamDataIn,
  output logic                 RamWriteEnable,
  input  logic [DATAWIDTH-1:0] RamDataOut
);

  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

  lock_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        force_q, force_d;
  logic        force_id_q, force_id_d;

  logic     owner_id, owner_valid, locked, hold, tie;
  logic     tie_pick, tie_win;
  logic     grant_any, grant_id;
  logic     g_wen, g_lock;
  rsp_tag_t tag_push, tag_pop;

  always_comb begin
    locked      = (state_q != UNLOCKED);
    owner_id    = (state_q == LOCKED1) ? REQ1 : REQ0;
    owner_valid = (owner_id == REQ1) ? Req1Valid : Req0Valid;
    hold        = locked && owner_valid;
    tie         = !hold && Req0Valid && Req1Valid;
`ifdef SYNCORE_RAM_ARB_RR_EN
    tie_pick    = other_id(last_q);
`else
    tie_pick    = REQ0;
`endif
    // A forced MAX_BURST release overrides the tie policy exactly once.
    tie_win     = force_q ? force_id_q : tie_pick;
    grant_any   = PortResetN && (Req0Valid || Req1Valid);
    if (hold) begin
      grant_id = owner_id;
    end else if (tie) begin
      grant_id = tie_win;
    end else begin
      grant_id = Req0Valid ? REQ0 : REQ1;
    end
  end

  always_comb begin
    Req0Ready      = grant_any && (grant_id == REQ0);
    Req1Ready      = grant_any && (grant_id == REQ1);
    g_wen          = (grant_id == REQ1) ? Req1Wen  : Req0Wen;
    g_lock         = (grant_id == REQ1) ? Req1Lock : Req0Lock;
    RamWriteEnable = grant_any && g_wen;
    RamAddr        = '0;
    RamDataIn      = '0;
    if (grant_any) begin
      RamAddr   = (grant_id == REQ1) ? Req1Addr  : Req0Addr;
      RamDataIn = (grant_id == REQ1) ? Req1WData : Req0WData;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    force_d    = force_q;
    force_id_d = force_id_q;
    if (tie) begin
      force_d = 1'b0;
    end
    if (locked && !owner_valid) begin
      state_d = UNLOCKED;
      cnt_d   = 8'd0;
    end
    if (grant_any) begin
      last_d = grant_id;
      if (hold) begin
        if (!g_lock) begin
          state_d = UNLOCKED;
          cnt_d   = 8'd0;
        end else if (cnt_q + 8'd1 == MAX_BURST_C) begin
          state_d    = UNLOCKED;
          cnt_d      = 8'd0;
          force_d    = 1'b1;
          force_id_d = other_id(grant_id);
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end else if (g_lock) begin
        state_d = (grant_id == REQ1) ? LOCKED1 : LOCKED0;
        cnt_d   = 8'd1;
      end
    end
  end

  always_ff @(posedge PortClk or negedge PortResetN) begin
    if (!PortResetN) begin
      state_q    <= UNLOCKED;
      cnt_q      <= 8'd0;
      last_q     <= REQ1;
      force_q    <= 1'b0;
      force_id_q <= REQ0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      force_q    <= force_d;
      force_id_q <= force_id_d;
    end
  end

  always_comb begin
    tag_push.valid = grant_any && !g_wen;
    tag_push.id    = grant_id;
  end

  syncore_ram_arb_rsp_pipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_rsp_pipe (
    .clk     (PortClk),
    .rst_n   (PortResetN),
    .tag_in  (tag_push),
    .tag_out (tag_pop)
  );

  assign Rsp0Valid = tag_pop.valid && (tag_pop.id == REQ0);
  assign Rsp1Valid = tag_pop.valid && (tag_pop.id == REQ1);
  assign Rsp0Data  = RamDataOut;
  assign Rsp1Data  = RamDataOut;

endmodule

`default_nettype wire
